// File: rtl/pb_conditioner.sv
// Pushbutton front end: per-button 2-flop synchronizer, counter debounce and
// rising-edge pulse. Optional macro PB_TIE_SUPPRESS_EN drops same-edge ties.

module pb_chan #(
  parameter int DB_CYCLES = 50000,
  parameter int CNT_W     = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic lvl_o,
  output logic rise_o
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic             s1_q, s2_q;
  logic             lvl_q, lvl_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any sample matching the accepted level restarts the qualification window.
  always_comb begin
    lvl_d = lvl_q;
    cnt_d = cnt_q;
    if (s2_q == lvl_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      lvl_d = s2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      lvl_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= raw_i;
      s2_q  <= s1_q;
      lvl_q <= lvl_d;
      cnt_q <= cnt_d;
    end
  end

  assign lvl_o  = lvl_q;
  assign rise_o = lvl_d & ~lvl_q;
endmodule

module pb_conditioner #(
  parameter int DB_CYCLES = 50000,
  parameter int CNT_W     = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic pbl_raw,
  input  logic pbr_raw,
  output logic pbl,
  output logic pbr,
  output logic pbl_level,
  output logic pbr_level
);
  logic [1:0] raw, lvl, rise;
  logic [1:0] pulse_d, pulse_q;

  assign raw = {pbr_raw, pbl_raw};

  for (genvar g = 0; g < 2; g++) begin : g_ch
    pb_chan #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_ch (
      .clk   (clk),
      .rst   (rst),
      .raw_i (raw[g]),
      .lvl_o (lvl[g]),
      .rise_o(rise[g])
    );
  end

  always_comb begin
    pulse_d = rise;
`ifdef PB_TIE_SUPPRESS_EN
    // A same-edge tie is discarded; levels still update.
    if (&rise) pulse_d = 2'b00;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pulse_q <= 2'b00;
    else     pulse_q <= pulse_d;
  end

  assign pbl       = pulse_q[0];
  assign pbr       = pulse_q[1];
  assign pbl_level = lvl[0];
  assign pbr_level = lvl[1];
endmodule

// File: tb/tb_pb_conditioner.sv
// Directed bench for pb_conditioner (DB_CYCLES=4) with a sliding-window
// reference model checked every cycle plus hand-computed event timings.

module tb_pb_conditioner;
  localparam int DB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pbl_raw = 1'b0, pbr_raw = 1'b0;
  logic pbl, pbr, pbl_level, pbr_level;

  int total = 0, bad = 0;
  int cyc = 0;

  pb_conditioner #(.DB_CYCLES(DB), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .pbl_raw(pbl_raw), .pbr_raw(pbr_raw),
    .pbl(pbl), .pbr(pbr), .pbl_level(pbl_level), .pbr_level(pbr_level)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: the level flips once the raw samples taken 2..DB+1 edges ago all
  // disagree with it. Pre-reset history counts as zeros.
  bit hl[$], hr[$];
  bit m_lvl_l, m_lvl_r, m_pl, m_pr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hl.delete(); hr.delete();
      for (int i = 0; i < DB + 2; i++) begin hl.push_back(1'b0); hr.push_back(1'b0); end
      m_lvl_l = 0; m_lvl_r = 0; m_pl = 0; m_pr = 0;
    end else begin
      bit fl, fr, rl, rr;
      int n;
      hl.push_back(pbl_raw);
      hr.push_back(pbr_raw);
      n = hl.size() - 1;
      fl = 1; fr = 1;
      for (int k = 2; k <= DB + 1; k++) begin
        if (hl[n-k] == m_lvl_l) fl = 0;
        if (hr[n-k] == m_lvl_r) fr = 0;
      end
      rl = fl && !m_lvl_l;
      rr = fr && !m_lvl_r;
      if (fl) m_lvl_l = !m_lvl_l;
      if (fr) m_lvl_r = !m_lvl_r;
      m_pl = rl; m_pr = rr;
`ifdef PB_TIE_SUPPRESS_EN
      if (rl && rr) begin m_pl = 0; m_pr = 0; end
`endif
    end
  end

  // Event bookkeeping for the directed literal checks.
  int npl, npr, firstl, lastl, lastr, lrise_l, lrise_r;
  bit seen_l;

  always @(negedge clk) begin
    chk("pbl", pbl, m_pl);
    chk("pbr", pbr, m_pr);
    chk("pbl_level", pbl_level, m_lvl_l);
    chk("pbr_level", pbr_level, m_lvl_r);
    if (pbl) begin if (npl == 0) firstl = cyc; lastl = cyc; npl++; end
    if (pbr) begin lastr = cyc; npr++; end
    if (pbl_level) begin if (!seen_l) lrise_l = cyc; seen_l = 1; end
    if (pbr_level && lrise_r < 0) lrise_r = cyc;
  end

  task automatic sync();
    @(negedge clk); #2;
  endtask

  task automatic clr();
    npl = 0; npr = 0; firstl = -1; lastl = -1; lastr = -1;
    lrise_l = -1; lrise_r = -1; seen_l = 0;
  endtask

  task automatic step(input int n);
    repeat (n) sync();
  endtask

  int t0;

  initial begin
    clr();
    step(3);
    rst = 1'b0;
    step(2);
    chk("reset_pbl_level", pbl_level, 0);
    chk("reset_pbl", pbl, 0);

    // Clean left press held 40 cycles
    clr(); t0 = cyc; pbl_raw = 1'b1;
    step(40);
    chk("press_count", npl, 1);
    chk("press_edge", lastl, t0 + 6);
    chk("press_level_edge", lrise_l, t0 + 6);
    chk("press_pbr_quiet", npr, 0);
    chk("press_level_held", pbl_level, 1);

    // Async reset mid-cycle while held, then re-qualification
    @(posedge clk); #5; rst = 1'b1; #1;
    chk("async_rst_level", pbl_level, 0);
    chk("async_rst_pbl", pbl, 0);
    chk("async_rst_pbr", pbr, 0);
    @(negedge clk); #2; rst = 1'b0; clr(); t0 = cyc;
    step(12);
    chk("rst_requal_count", npl, 1);
    chk("rst_requal_edge", lastl, t0 + 6);
    pbl_raw = 1'b0;
    step(10);

    // Bounce on right button
    clr();
    pbr_raw = 1'b1; step(1);
    pbr_raw = 1'b0; step(1);
    pbr_raw = 1'b1; step(1);
    pbr_raw = 1'b0; step(1);
    t0 = cyc; pbr_raw = 1'b1;
    step(15);
    chk("bounce_count", npr, 1);
    chk("bounce_edge", lastr, t0 + 6);
    chk("bounce_pbl_quiet", npl, 0);
    pbr_raw = 1'b0;
    step(10);

    // Glitch: 3 cycles high
    clr(); pbl_raw = 1'b1; step(3); pbl_raw = 1'b0; step(10);
    chk("glitch_pulses", npl, 0);
    chk("glitch_level", int'(seen_l), 0);

    // Press, release, press
    clr(); t0 = cyc;
    pbl_raw = 1'b1; step(10);
    pbl_raw = 1'b0; step(10);
    pbl_raw = 1'b1; step(10);
    pbl_raw = 1'b0; step(10);
    chk("prp_count", npl, 2);
    chk("prp_first", firstl, t0 + 6);
    chk("prp_spacing", lastl - firstl, 20);

    // Simultaneous press
    clr(); t0 = cyc; pbl_raw = 1'b1; pbr_raw = 1'b1;
    step(10);
    chk("tie_lvl_l_edge", lrise_l, t0 + 6);
    chk("tie_lvl_r_edge", lrise_r, t0 + 6);
`ifdef PB_TIE_SUPPRESS_EN
    chk("tie_pbl_count", npl, 0);
    chk("tie_pbr_count", npr, 0);
`else
    chk("tie_pbl_edge", lastl, t0 + 6);
    chk("tie_pbr_edge", lastr, t0 + 6);
`endif
    pbl_raw = 1'b0; pbr_raw = 1'b0;
    step(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
